// File: rtl/qeciphy_tx_pkg.sv
// Shared types for the QECIPHY TX lane multiplexer.
// Holds the link FSM state encoding, beat counter width and small sizing helpers.
// Imported by the lane mux top; the FIFO sub-module has no dependency on it.
package qeciphy_tx_pkg;

  // Link state: RUN passes traffic, DRAIN flushes buffers, HALT is powered-down idle
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } tx_state_t;

  // Width of each per-lane sent-beat counter
  localparam int BEAT_CNT_W = 32;

  // Channel-id width; a single lane still carries a 1-bit id tied to zero
  function automatic int ch_id_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/qeciphy_sync_fifo.sv
// Single-clock show-ahead FIFO, depth 2**FIFO_AW, one lane of the TX mux.
// Latency: a write is visible on rdata/empty the cycle after it; no write-to-read bypass.
// Backpressure: full/empty derive from the registered count; writes when full and reads when empty are ignored.
module qeciphy_sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_AW:0]      count
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full  = (count == (FIFO_AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wen & ~full;
  assign do_rd = ren & ~empty;

  // Head entry is presented combinationally so the arbiter can load it directly
  assign rdata = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; reset discards everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (FIFO_AW + 1)'(1);
        2'b01:   count <= count - (FIFO_AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/qeciphy_tx_lanemux.sv
// Round-robin aggregator of NUM_CH valid/ready lanes into one channel-tagged beat stream.
// Latency: beat accepted at edge k is on o_data/o_valid after edge k+1 (idle output, lane wins).
// Backpressure: per-lane FIFO full or link gate drops o_ready; output holds while o_valid & ~i_ready.
// Optional per-lane beat counters are built when QECIPHY_TX_STATS_EN is defined.
module qeciphy_tx_lanemux
  import qeciphy_tx_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_AW    = 4
) (
  input  logic                           tx_clk,
  input  logic                           tx_rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   i_data,
  input  logic [NUM_CH-1:0]              i_valid,
  output logic [NUM_CH-1:0]              o_ready,
  input  logic                           i_remote_rx_rdy,
  input  logic                           i_pd_req,
  input  logic                           i_pd_ack,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic [ch_id_w(NUM_CH)-1:0]     o_ch_id,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic                           o_drained,
  input  logic                           i_stats_clr,
  output logic [NUM_CH*BEAT_CNT_W-1:0]   o_beat_cnt
);

  localparam int CH_W = ch_id_w(NUM_CH);

  tx_state_t             state;
  logic                  gate;
  logic [NUM_CH-1:0]     fifo_full;
  logic [NUM_CH-1:0]     fifo_empty;
  logic [NUM_CH-1:0]     fifo_wen;
  logic [NUM_CH-1:0]     fifo_ren;
  logic [DATA_WIDTH-1:0] fifo_rdata [NUM_CH];
  logic [FIFO_AW:0]      fifo_count_unused [NUM_CH];
  logic                  all_empty;
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       grant_idx;
  logic [CH_W-1:0]       cand_idx;
  logic                  grant_vld;
  logic                  out_load;
  int                    cand;

  // Input gate uses the registered state, so a power-down request only
  // affects the handshake through its own combinational term
  assign gate      = i_remote_rx_rdy & ~i_pd_req & ~i_pd_ack & (state == ST_RUN);
  assign o_ready   = ~fifo_full & {NUM_CH{gate & ~tx_rst}};
  assign fifo_wen  = i_valid & o_ready;
  assign all_empty = &fifo_empty;

  // Output register accepts a new beat whenever it is free or being consumed
  assign out_load  = (~o_valid | i_ready) & grant_vld;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_lane
      qeciphy_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_AW    (FIFO_AW)
      ) u_fifo (
        .clk   (tx_clk),
        .rst   (tx_rst),
        .wen   (fifo_wen[c]),
        .wdata (i_data[c*DATA_WIDTH +: DATA_WIDTH]),
        .ren   (fifo_ren[c]),
        .rdata (fifo_rdata[c]),
        .full  (fifo_full[c]),
        .empty (fifo_empty[c]),
        .count (fifo_count_unused[c])
      );
    end
  endgenerate

  // Round-robin search: first non-empty lane at or after rr_ptr, wrapping
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      cand_idx = CH_W'(cand);
      if (!grant_vld && !fifo_empty[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Pop only the granted lane, and only when the output stage takes its beat
  always_comb begin
    fifo_ren = '0;
    if (out_load) begin
      fifo_ren[grant_idx] = 1'b1;
    end
  end

  // Registered output stage and arbiter pointer; pointer moves past each winner
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch_id <= '0;
      rr_ptr  <= '0;
    end else if (out_load) begin
      o_valid <= 1'b1;
      o_data  <= fifo_rdata[grant_idx];
      o_ch_id <= grant_idx;
      rr_ptr  <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Link FSM: power-down blocks inputs, lets buffered beats drain, then halts
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state     <= ST_RUN;
      o_drained <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (i_pd_req) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // A dropped request does not abort the drain; HALT is always visited
          if (all_empty && !o_valid) begin
            state     <= ST_HALT;
            o_drained <= 1'b1;
          end
        end
        ST_HALT: begin
          if (!i_pd_req && !i_pd_ack) begin
            state     <= ST_RUN;
            o_drained <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          o_drained <= 1'b0;
        end
      endcase
    end
  end

`ifdef QECIPHY_TX_STATS_EN
  logic [BEAT_CNT_W-1:0] beat_cnt [NUM_CH];
  logic                  beat_fire;

  assign beat_fire = o_valid & i_ready;

  // Per-lane sent-beat counters; clear takes priority over a same-cycle beat
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        beat_cnt[i] <= '0;
      end
    end else if (i_stats_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        beat_cnt[i] <= '0;
      end
    end else if (beat_fire) begin
      beat_cnt[o_ch_id] <= beat_cnt[o_ch_id] + BEAT_CNT_W'(1);
    end
  end

  genvar s;
  generate
    for (s = 0; s < NUM_CH; s++) begin : g_stats
      assign o_beat_cnt[s*BEAT_CNT_W +: BEAT_CNT_W] = beat_cnt[s];
    end
  endgenerate
`else
  logic unused_stats_clr;

  assign o_beat_cnt       = '0;
  assign unused_stats_clr = i_stats_clr;
`endif

endmodule
